// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side signal bundle for ram_arbiter
interface ram_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              boot_req, cpu_req, dbg_req;
  logic              boot_we, cpu_we, dbg_we;
  logic [ADDR_W-1:0] boot_adr, cpu_adr, dbg_adr;
  logic [DATA_W-1:0] boot_wdata, cpu_wdata, dbg_wdata;
  logic              boot_lock;
  logic              boot_gnt, cpu_gnt, dbg_gnt;
  logic              boot_rvalid, cpu_rvalid, dbg_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_add;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_r_w;
  logic              ram_enable;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  boot_req, cpu_req, dbg_req, boot_we, cpu_we, dbg_we,
           boot_adr, cpu_adr, dbg_adr, boot_wdata, cpu_wdata, dbg_wdata,
           boot_lock, ram_data_out,
    output boot_gnt, cpu_gnt, dbg_gnt, boot_rvalid, cpu_rvalid, dbg_rvalid,
           rdata, ram_add, ram_data_in, ram_r_w, ram_enable
  );

  modport master (
    output boot_req, cpu_req, dbg_req, boot_we, cpu_we, dbg_we,
           boot_adr, cpu_adr, dbg_adr, boot_wdata, cpu_wdata, dbg_wdata,
           boot_lock, ram_data_out,
    input  boot_gnt, cpu_gnt, dbg_gnt, boot_rvalid, cpu_rvalid, dbg_rvalid,
           rdata, ram_add, ram_data_in, ram_r_w, ram_enable
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - three-way arbiter for the single-port program/data RAM
module ram_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  ram_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic [2:0] rvalid_q, rvalid_d;   // {boot, cpu, dbg}
  logic       boot_gnt, cpu_gnt, dbg_gnt;
  logic       hold_lock, promoted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= 8'd0;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    boot_gnt  = 1'b0;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    // Dropping boot_lock releases the lock for the current cycle's arbitration.
    hold_lock = (state_q == LOCKED) && bus.boot_lock;
    promoted  = (starve_q == 8'(STARVE_MAX));
    if (ce && rst) begin
      if (bus.boot_req) begin
        boot_gnt = 1'b1;
      end else if (!hold_lock) begin
        if (bus.dbg_req && promoted) begin
          dbg_gnt = 1'b1;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (bus.dbg_req) begin
          dbg_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.ram_enable  = 1'b0;
    bus.ram_r_w     = 1'b0;
    bus.ram_add     = '0;
    bus.ram_data_in = '0;
    if (boot_gnt) begin
      bus.ram_enable  = 1'b1;
      bus.ram_r_w     = bus.boot_we;
      bus.ram_add     = bus.boot_adr;
      bus.ram_data_in = bus.boot_wdata;
    end else if (cpu_gnt) begin
      bus.ram_enable  = 1'b1;
      bus.ram_r_w     = bus.cpu_we;
      bus.ram_add     = bus.cpu_adr;
      bus.ram_data_in = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      bus.ram_enable  = 1'b1;
      bus.ram_r_w     = bus.dbg_we;
      bus.ram_add     = bus.dbg_adr;
      bus.ram_data_in = bus.dbg_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    rvalid_d = rvalid_q;
    if (ce) begin
      case (state_q)
        IDLE:    if (boot_gnt && bus.boot_lock) state_d = LOCKED;
        LOCKED:  if (!bus.boot_lock) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (dbg_gnt || !bus.dbg_req) begin
        starve_d = 8'd0;
      end else if (starve_q < 8'(STARVE_MAX)) begin
        starve_d = starve_q + 8'd1;
      end
      rvalid_d = {boot_gnt && !bus.boot_we, cpu_gnt && !bus.cpu_we, dbg_gnt && !bus.dbg_we};
    end
  end

  assign bus.boot_gnt    = boot_gnt;
  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.boot_rvalid = rvalid_q[2];
  assign bus.cpu_rvalid  = rvalid_q[1];
  assign bus.dbg_rvalid  = rvalid_q[0];
  assign bus.rdata       = bus.ram_data_out;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed, table-driven bench for ram_arbiter with a RAM model
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  ram_arbiter_if bif ();

  ram_arbiter #(.ADDR_W(6), .DATA_W(16), .STARVE_MAX(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .ce  (ce),
    .bus (bif)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (ce && bif.ram_enable) begin
      if (bif.ram_r_w) mem[bif.ram_add] <= bif.ram_data_in;
      else             bif.ram_data_out <= mem[bif.ram_add];
    end
  end

  typedef struct {
    logic        ce;
    logic        b_req, b_we, b_lock;
    logic [5:0]  b_adr;
    logic [15:0] b_wd;
    logic        c_req, c_we;
    logic [5:0]  c_adr;
    logic        d_req, d_we;
    logic [5:0]  d_adr;
    logic [2:0]  e_gnt, e_rv;
    logic        e_en, e_rw;
    logic [5:0]  e_add;
    logic [15:0] e_rd;
    logic        chk_rd;
  } vec_t;

  function automatic vec_t v(logic c, logic br, logic bw, logic bl, logic [5:0] ba, logic [15:0] bd,
                             logic cr, logic cw, logic [5:0] ca, logic dr, logic dw, logic [5:0] da,
                             logic [2:0] eg, logic [2:0] erv, logic een, logic erw, logic [5:0] ead,
                             logic [15:0] erd, logic crd);
    vec_t r;
    r.ce = c; r.b_req = br; r.b_we = bw; r.b_lock = bl; r.b_adr = ba; r.b_wd = bd;
    r.c_req = cr; r.c_we = cw; r.c_adr = ca; r.d_req = dr; r.d_we = dw; r.d_adr = da;
    r.e_gnt = eg; r.e_rv = erv; r.e_en = een; r.e_rw = erw; r.e_add = ead; r.e_rd = erd; r.chk_rd = crd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] gnt3();
    return {bif.boot_gnt, bif.cpu_gnt, bif.dbg_gnt};
  endfunction

  function automatic logic [2:0] rv3();
    return {bif.boot_rvalid, bif.cpu_rvalid, bif.dbg_rvalid};
  endfunction

  task automatic drive(input logic c, input logic br, input logic bw, input logic bl,
                       input logic [5:0] ba, input logic [15:0] bd, input logic cr, input logic cw,
                       input logic [5:0] ca, input logic dr, input logic dw, input logic [5:0] da);
    ce = c;
    bif.boot_req = br; bif.boot_we = bw; bif.boot_lock = bl; bif.boot_adr = ba; bif.boot_wdata = bd;
    bif.cpu_req = cr;  bif.cpu_we = cw;  bif.cpu_adr = ca;   bif.cpu_wdata = 16'hC000;
    bif.dbg_req = dr;  bif.dbg_we = dw;  bif.dbg_adr = da;   bif.dbg_wdata = 16'hD000;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [23];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA500 + 16'(i);
    bif.ram_data_out = 16'h0000;

    // ce, boot{req,we,lock,adr,wd}, cpu{req,we,adr}, dbg{req,we,adr}, exp{gnt,rv,en,rw,add,rdata,chk}
    vt[0]  = v(1, 0,0,0,6'h00,16'h0000, 1,0,6'h05, 1,0,6'h06, 3'b010,3'b000,1,0,6'h05,16'h0000,0);
    vt[1]  = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 1,0,6'h06, 3'b001,3'b010,1,0,6'h06,16'hA505,1);
    vt[2]  = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00, 3'b000,3'b001,0,0,6'h00,16'hA506,1);
    vt[3]  = v(1, 1,1,1,6'h00,16'h1110, 1,0,6'h10, 0,0,6'h00, 3'b100,3'b000,1,1,6'h00,16'h0000,0);
    vt[4]  = v(1, 0,0,1,6'h00,16'h0000, 1,0,6'h10, 0,0,6'h00, 3'b000,3'b000,0,0,6'h00,16'h0000,0);
    vt[5]  = v(1, 1,1,1,6'h01,16'h1111, 1,0,6'h10, 0,0,6'h00, 3'b100,3'b000,1,1,6'h01,16'h0000,0);
    vt[6]  = v(0, 1,1,1,6'h02,16'h1112, 1,0,6'h10, 0,0,6'h00, 3'b000,3'b000,0,0,6'h00,16'h0000,0);
    vt[7]  = v(1, 1,1,1,6'h02,16'h1112, 1,0,6'h10, 0,0,6'h00, 3'b100,3'b000,1,1,6'h02,16'h0000,0);
    vt[8]  = v(1, 1,1,1,6'h03,16'h1113, 1,0,6'h10, 0,0,6'h00, 3'b100,3'b000,1,1,6'h03,16'h0000,0);
    vt[9]  = v(1, 0,0,0,6'h00,16'h0000, 1,0,6'h02, 0,0,6'h00, 3'b010,3'b000,1,0,6'h02,16'h0000,0);
    vt[10] = v(1, 0,0,0,6'h00,16'h0000, 1,0,6'h03, 0,0,6'h00, 3'b010,3'b010,1,0,6'h03,16'h1112,1);
    vt[11] = v(0, 0,0,0,6'h00,16'h0000, 1,0,6'h00, 0,0,6'h00, 3'b000,3'b010,0,0,6'h00,16'h1113,1);
    vt[12] = v(1, 0,0,0,6'h00,16'h0000, 1,0,6'h00, 0,0,6'h00, 3'b010,3'b010,1,0,6'h00,16'h1113,1);
    vt[13] = v(0, 0,0,0,6'h00,16'h0000, 1,0,6'h01, 0,0,6'h00, 3'b000,3'b010,0,0,6'h00,16'h1110,1);
    vt[14] = v(1, 0,0,0,6'h00,16'h0000, 1,0,6'h01, 0,0,6'h00, 3'b010,3'b010,1,0,6'h01,16'h1110,1);
    vt[15] = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00, 3'b000,3'b010,0,0,6'h00,16'h1111,1);
    vt[16] = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00, 3'b000,3'b000,0,0,6'h00,16'h0000,0);
    vt[17] = v(1, 0,0,1,6'h00,16'h0000, 1,0,6'h05, 0,0,6'h00, 3'b010,3'b000,1,0,6'h05,16'h0000,0);
    vt[18] = v(1, 0,0,1,6'h00,16'h0000, 1,0,6'h06, 0,0,6'h00, 3'b010,3'b010,1,0,6'h06,16'hA505,1);
    vt[19] = v(1, 1,0,0,6'h04,16'h0000, 0,0,6'h00, 0,0,6'h00, 3'b100,3'b010,1,0,6'h04,16'hA506,1);
    vt[20] = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00, 3'b000,3'b100,0,0,6'h00,16'hA504,1);
    vt[21] = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 1,1,6'h07, 3'b001,3'b000,1,1,6'h07,16'h0000,0);
    vt[22] = v(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00, 3'b000,3'b000,0,0,6'h00,16'h0000,0);

    // Reset held with every requester asking
    rst_n = 1'b0;
    drive(1, 1,0,0,6'h00,16'h0000, 1,0,6'h01, 1,0,6'h02);
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt3()), 32'b000);
    chk("rst_rvalid", 32'(rv3()), 32'b000);
    chk("rst_enable", 32'(bif.ram_enable), 32'd0);
    chk("rst_add", 32'(bif.ram_add), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_boot_gnt", 32'(gnt3()), 32'b100);
    next_cycle();
    drive(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00);
    @(negedge clk);
    chk("rel_boot_rvalid", 32'(rv3()), 32'b100);
    next_cycle();

    for (int i = 0; i < 23; i++) begin
      drive(vt[i].ce, vt[i].b_req, vt[i].b_we, vt[i].b_lock, vt[i].b_adr, vt[i].b_wd,
            vt[i].c_req, vt[i].c_we, vt[i].c_adr, vt[i].d_req, vt[i].d_we, vt[i].d_adr);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt3()), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rv3()), 32'(vt[i].e_rv));
      chk($sformatf("v%0d_enable", i), 32'(bif.ram_enable), 32'(vt[i].e_en));
      chk($sformatf("v%0d_r_w", i), 32'(bif.ram_r_w), 32'(vt[i].e_rw));
      chk($sformatf("v%0d_add", i), 32'(bif.ram_add), 32'(vt[i].e_add));
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), 32'(bif.rdata), 32'(vt[i].e_rd));
      next_cycle();
    end
    chk("mem_boot_data", {mem[0], mem[3]}, {16'h1110, 16'h1113});

    // Starvation: debug promoted on the 9th waiting cycle
    drive(1, 0,0,0,6'h00,16'h0000, 1,0,6'h08, 1,0,6'h09);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("starve_a%0d_gnt", k), 32'(gnt3()), (k == 9) ? 32'b001 : 32'b010);
      next_cycle();
    end
    drive(1, 0,0,0,6'h00,16'h0000, 1,0,6'h08, 0,0,6'h00);
    @(negedge clk);
    chk("starve_cpu_resume", 32'(gnt3()), 32'b010);
    next_cycle();

    // Starvation again, with boot colliding against the promoted debug request
    drive(1, 0,0,0,6'h00,16'h0000, 1,0,6'h08, 1,0,6'h09);
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) begin
        bif.boot_req = 1'b1;
        bif.boot_adr = 6'h0A;
      end
      @(negedge clk);
      chk($sformatf("starve_b%0d_gnt", k), 32'(gnt3()), (k == 9) ? 32'b100 : 32'b010);
      next_cycle();
    end
    bif.boot_req = 1'b0;
    @(negedge clk);
    chk("starve_dbg_after_boot", 32'(gnt3()), 32'b001);
    next_cycle();
    drive(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00);
    next_cycle();

    // Reset while locked with a boot read in flight
    drive(1, 1,1,1,6'h10,16'hBEEF, 0,0,6'h00, 0,0,6'h00);
    @(negedge clk);
    chk("lk_wr_gnt", 32'(gnt3()), 32'b100);
    next_cycle();
    drive(1, 1,0,1,6'h10,16'h0000, 0,0,6'h00, 0,0,6'h00);
    next_cycle();
    drive(1, 0,0,1,6'h00,16'h0000, 1,0,6'h11, 0,0,6'h00);
    @(negedge clk);
    chk("lk_cpu_blocked", 32'(gnt3()), 32'b000);
    chk("lk_boot_rvalid", 32'(rv3()), 32'b100);
    chk("lk_boot_rdata", 32'(bif.rdata), 32'hBEEF);
    #1 rst_n = 1'b0;
    #1 chk("lk_rst_rvalid", 32'(rv3()), 32'b000);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lk_idle_after_rst", 32'(gnt3()), 32'b010);
    next_cycle();

    // Reset in the cycle after a debug read grant
    drive(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 1,0,6'h12);
    @(negedge clk);
    chk("dr_gnt", 32'(gnt3()), 32'b001);
    next_cycle();
    drive(1, 0,0,0,6'h00,16'h0000, 0,0,6'h00, 0,0,6'h00);
    @(negedge clk);
    chk("dr_rvalid", 32'(rv3()), 32'b001);
    #1 rst_n = 1'b0;
    #1 chk("dr_rst_rvalid", 32'(rv3()), 32'b000);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("dr_after_rst_rvalid", 32'(rv3()), 32'b000);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 64x16 program/data RAM between three requesters: the boot loader (serial download/scan), the CPU control unit and a debug reader. Each requester has its own req/gnt port; one access per granted clock-enabled cycle. Read data returns one cycle later with a per-requester valid strobe. The block replaces the static boot-select multiplexer in front of the RAM and adds burst locking and starvation protection for the debug port.

## Interface
- ADDR_W, 6, RAM address width
- DATA_W, 16, RAM data width
- STARVE_MAX, 8, waiting ce-cycles after which a debug request is promoted above the CPU (range 1..255)

- clk  in  1  system clock, all registers on rising edge
- rst  in  1  reset; asynchronous, active-low
- ce  in  1  clock enable; registers update and grants issue only when ce=1
- boot_req, cpu_req, dbg_req  in  1 each  access request, held until granted
- boot_we, cpu_we, dbg_we  in  1 each  1=write, 0=read
- boot_adr, cpu_adr, dbg_adr  in  ADDR_W each  access address
- boot_wdata, cpu_wdata, dbg_wdata  in  DATA_W each  write data
- boot_lock  in  1  boot loader holds the RAM for a burst
- boot_gnt, cpu_gnt, dbg_gnt  out  1 each  access performed this cycle
- boot_rvalid, cpu_rvalid, dbg_rvalid  out  1 each  rdata valid for this requester's read
- rdata  out  DATA_W  read data, direct from ram_data_out
- ram_add  out  ADDR_W  RAM address
- ram_data_in  out  DATA_W  RAM write data
- ram_r_w  out  1  RAM write strobe (1=write)
- ram_enable  out  1  RAM enable
- ram_data_out  in  DATA_W  RAM synchronous read data

## Operation
- States: IDLE, LOCKED. Reset -> IDLE.
- IDLE arbitration, evaluated combinationally each cycle with ce=1: boot > promoted dbg > cpu > dbg. dbg is promoted when starve_cnt == STARVE_MAX.
- LOCKED: only boot may be granted; cpu/dbg gnt forced 0, their requests wait (starve_cnt still counts, saturating).
- IDLE -> LOCKED: ce=1, boot_gnt=1, boot_lock=1.
- LOCKED -> IDLE: ce=1, boot_lock=0. Arbitration in that same cycle is already IDLE rules.
- At most one gnt high per cycle; gnt never high when ce=0 or rst=0.
- Winner's adr/wdata/we drive ram_add/ram_data_in/ram_r_w; ram_enable=1. No winner: ram_enable=0, ram_r_w=0, ram_add=0, ram_data_in=0.
- starve_cnt (8-bit): cleared when dbg_gnt=1 or dbg_req=0; else +1 per ce cycle, saturating at STARVE_MAX.
- Read return: a granted read (we=0) sets that requester's rvalid register at the next ce edge; cleared at any ce edge without a new granted read for it. Writes never raise rvalid.
- Registers hold while ce=0; rvalid stays as last registered, consumers qualify it with ce.

## Timing
- Grant: same cycle as req if the requester wins (0-cycle arbitration).
- Write: committed by RAM at the granted ce edge.
- Read latency: 1 ce cycle; rvalid and rdata valid in the cycle after gnt.
- Back-to-back granted reads by one requester: rvalid held high continuously, rdata updates per cycle.
- Reset values: all gnt 0, all rvalid 0, ram_enable 0, ram_r_w 0, ram_add 0, ram_data_in 0, state IDLE, starve_cnt 0.
- rst asserted mid-read: rvalid cleared immediately (async); the read result is discarded, no re-issue.
- Simultaneous boot_req and promoted dbg: boot wins, starve_cnt stays at STARVE_MAX, dbg wins the next cycle without boot_req (LOCKED excepted).
- boot_lock high without boot_gnt: no state change.

## Test plan
- Reset: hold rst=0, drive all req=1 -> all gnt/rvalid/ram_enable 0; release -> boot_gnt=1 in first ce cycle.
- Priority: cpu_req and dbg_req together, reads at 0x05 and 0x06 -> cpu_gnt cycle 0, rvalid for cpu cycle 1 with RAM[0x05]; dbg_gnt cycle 1, dbg_rvalid cycle 2 with RAM[0x06].
- Starvation: cpu_req constant, dbg_req held, STARVE_MAX=8 -> dbg_gnt exactly on 9th cycle, starve_cnt back to 0, cpu resumes next cycle.
- Lock: boot writes 0x00..0x03 with boot_lock=1 and idle gaps, cpu_req=1 throughout -> cpu_gnt 0 until the cycle boot_lock=0; RAM holds boot data.
- ce gating: ce toggling 1/0 during cpu read stream -> gnt only in ce=1 cycles, rvalid lags one ce-high cycle, no duplicated/lost reads.
- Reset mid-read: rst low in cycle after dbg_gnt read -> dbg_rvalid 0 immediately, state IDLE after release.
